pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 159 +++++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with an optional circular return-address stack.
// Latency: every action is sampled on a rising clk edge and is visible on the
// registered outputs one cycle later. Backpressure: stall freezes all state.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   stall               hold pc, stack, pointer, count and sticky flags
//   intr_req, intr_vec  interrupt entry: push resume pc, jump to intr_vec
//   ret                 pop the stack into pc
//   call, target        push pc+STEP, jump to target
//   branch_taken        jump to target
//   pc                  current program counter
//   ras_count           number of valid stack entries
//   ras_overflow        sticky: a push happened while the stack was full
//   ras_underflow       sticky: a ret happened while the stack was empty
// Action priority: reset > stall > intr_req > ret > call > branch_taken > sequential.
// Build option: define PC_SEQ_RAS_EN to compile in the return-address stack.
// Without it, call acts as branch, ret acts as sequential, interrupts jump
// without pushing, and the stack status outputs read as zero.
module pc_sequencer #(
   parameter int ADDR_W    = 32,
   parameter int RESET_VEC = 30,
   parameter int STEP      = 2,
   parameter int RAS_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           stall,
   input  logic                           intr_req,
   input  logic [ADDR_W-1:0]              intr_vec,
   input  logic                           ret,
   input  logic                           call,
   input  logic                           branch_taken,
   input  logic [ADDR_W-1:0]              target,
   output logic [ADDR_W-1:0]              pc,
   output logic [$clog2(RAS_DEPTH):0]     ras_count,
   output logic                           ras_overflow,
   output logic                           ras_underflow
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_seq;

   // Natural ADDR_W-bit wrap gives the modulo 2^ADDR_W increment.
   assign pc_seq = pc_q + ADDR_W'(STEP);

`ifdef PC_SEQ_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // ptr_q addresses the next free slot; when the stack is full it also
   // addresses the oldest entry, so a push then overwrites the oldest.
   logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              push_en;
   logic [ADDR_W-1:0] push_dat;
   logic [ADDR_W-1:0] ras_top;

   assign ras_top = ras_mem_q[ptr_q - PTR_W'(1)];
`endif

   always_comb begin
      pc_d = pc_q;
`ifdef PC_SEQ_RAS_EN
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      push_en  = 1'b0;
      push_dat = pc_seq;
`endif
      if (reset) begin
         pc_d = ADDR_W'(RESET_VEC);
`ifdef PC_SEQ_RAS_EN
         ptr_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
         unf_d = 1'b0;
`endif
      end else if (stall) begin
         pc_d = pc_q;
      end else if (intr_req) begin
         pc_d = intr_vec;
`ifdef PC_SEQ_RAS_EN
         // Resume address is the interrupted pc itself, not pc+STEP.
         push_en  = 1'b1;
         push_dat = pc_q;
`endif
      end else if (ret) begin
`ifdef PC_SEQ_RAS_EN
         if (cnt_q != '0) begin
            pc_d  = ras_top;
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            pc_d  = pc_seq;
            unf_d = 1'b1;
         end
`else
         pc_d = pc_seq;
`endif
      end else if (call) begin
         pc_d = target;
`ifdef PC_SEQ_RAS_EN
         push_en  = 1'b1;
         push_dat = pc_seq;
`endif
      end else if (branch_taken) begin
         pc_d = target;
      end else begin
         pc_d = pc_seq;
      end

`ifdef PC_SEQ_RAS_EN
      if (push_en) begin
         ptr_d = ptr_q + PTR_W'(1);
         if (cnt_q == CNT_W'(RAS_DEPTH)) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      pc_q <= pc_d;
   end

   assign pc = pc_q;

`ifdef PC_SEQ_RAS_EN
   always_ff @(posedge clk) begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
   end

   // Entry storage carries no reset; push_en is already gated by reset.
   always_ff @(posedge clk) begin
      if (push_en) begin
         ras_mem_q[ptr_q] <= push_dat;
      end
   end

   assign ras_count     = cnt_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;
`else
   assign ras_count     = '0;
   assign ras_overflow  = 1'b0;
   assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset, stall, intr_req, ret, call, branch_taken;
   logic [AW-1:0] intr_vec, target;
   logic [AW-1:0] pc;
   logic [CW-1:0] ras_count;
   logic          ras_overflow, ras_underflow;

   always #5 clk = ~clk;

   pc_sequencer #(
      .ADDR_W(AW), .RESET_VEC(30), .STEP(2), .RAS_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .intr_req(intr_req), .intr_vec(intr_vec),
      .ret(ret), .call(call), .branch_taken(branch_taken), .target(target),
      .pc(pc), .ras_count(ras_count),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [CW-1:0] cnt;
      logic          ovf;
      logic          unf;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: stack kept as a queue, newest at the back.
   logic [AW-1:0] m_pc;
   logic [AW-1:0] m_stk[$];
   logic          m_ovf, m_unf;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic m_push(input logic [AW-1:0] v);
      m_stk.push_back(v);
      if (m_stk.size() > DEPTH) begin
         void'(m_stk.pop_front());
         m_ovf = 1'b1;
      end
   endtask

   task automatic model_step();
      logic [AW-1:0] nxt;
      nxt = m_pc + AW'(2);
      if (reset) begin
         m_pc = AW'(30);
         m_stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (stall) begin
         m_pc = m_pc;
      end else if (intr_req) begin
`ifdef PC_SEQ_RAS_EN
         m_push(m_pc);
`endif
         m_pc = intr_vec;
      end else if (ret) begin
`ifdef PC_SEQ_RAS_EN
         if (m_stk.size() > 0) begin
            m_pc = m_stk.pop_back();
         end else begin
            m_pc  = nxt;
            m_unf = 1'b1;
         end
`else
         m_pc = nxt;
`endif
      end else if (call) begin
`ifdef PC_SEQ_RAS_EN
         m_push(nxt);
`endif
         m_pc = target;
      end else if (branch_taken) begin
         m_pc = target;
      end else begin
         m_pc = nxt;
      end
   endtask

   // Drive one cycle of stimulus, queue the model's expectation, then
   // compare against the DUT just after the edge that consumes it.
   task automatic cyc(input string tag, input bit r, input bit st, input bit ir,
                      input logic [AW-1:0] iv, input bit rt, input bit cl,
                      input bit br, input logic [AW-1:0] tg);
      exp_t e;
      exp_t got_e;
      @(negedge clk);
      reset = r; stall = st; intr_req = ir; intr_vec = iv;
      ret = rt; call = cl; branch_taken = br; target = tg;
      model_step();
      e.pc  = m_pc;
`ifdef PC_SEQ_RAS_EN
      e.cnt = CW'(m_stk.size());
`else
      e.cnt = '0;
`endif
      e.ovf = m_ovf;
      e.unf = m_unf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got_e = exp_q.pop_front();
      check_eq({tag, ".pc"},  64'(pc),            64'(got_e.pc));
      check_eq({tag, ".cnt"}, 64'(ras_count),     64'(got_e.cnt));
      check_eq({tag, ".ovf"}, 64'(ras_overflow),  64'(got_e.ovf));
      check_eq({tag, ".unf"}, 64'(ras_underflow), 64'(got_e.unf));
   endtask

   task automatic idle(input string tag);
      cyc(tag, 0, 0, 0, '0, 0, 0, 0, '0);
   endtask

   task automatic br_to(input string tag, input logic [AW-1:0] a);
      cyc(tag, 0, 0, 0, '0, 0, 0, 1, a);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; intr_req = 1'b0; intr_vec = '0;
      ret = 1'b0; call = 1'b0; branch_taken = 1'b0; target = '0;
      m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;

      // Reset, then three sequential steps from the reset vector.
      cyc("reset", 1, 0, 0, '0, 0, 0, 0, '0);
      check_eq("reset_pc_const", 64'(pc), 64'd30);
      idle("seq1");
      idle("seq2");
      idle("seq3");
      check_eq("seq3_pc_const", 64'(pc), 64'd36);

      // Single call / return pair.
      br_to("br40", 32'h40);
      cyc("call100", 0, 0, 0, '0, 0, 1, 0, 32'h100);
      cyc("ret42", 0, 0, 0, '0, 1, 0, 0, '0);

      // Five nested calls overflow a four-deep stack; five returns underflow.
      for (int i = 0; i < 5; i++)
         cyc($sformatf("ncall%0d", i), 0, 0, 0, '0, 0, 1, 0, AW'(32'h1000 + i * 32'h10));
      for (int i = 0; i < 5; i++)
         cyc($sformatf("nret%0d", i), 0, 0, 0, '0, 1, 0, 0, '0);

      // Stall holds everything despite intr_req and call; interrupt afterwards.
      cyc("rst2", 1, 0, 0, '0, 0, 0, 0, '0);
      br_to("br300", 32'h300);
      for (int i = 0; i < 3; i++)
         cyc($sformatf("stall%0d", i), 0, 1, 1, 32'h200, 0, 1, 0, 32'h700);
      check_eq("stall_pc_const", 64'(pc), 64'h300);
      cyc("intr200", 0, 0, 1, 32'h200, 0, 0, 0, '0);
      cyc("intr_ret", 0, 0, 0, '0, 1, 0, 0, '0);

      // ret outranks call and branch when all three are asserted.
      br_to("br7e", 32'h7e);
      cyc("call500", 0, 0, 0, '0, 0, 1, 0, 32'h500);
      cyc("ret_all", 0, 0, 0, '0, 1, 1, 1, 32'h999);

      // Sequential wrap at the top of the address space.
      br_to("brtop", 32'hffff_fffe);
      idle("wrap");
      check_eq("wrap_pc_const", 64'(pc), 64'h0);

      // Reset overrides a stalled cycle right after a call.
      cyc("call_pre", 0, 0, 0, '0, 0, 1, 0, 32'h900);
      cyc("rst_stall", 1, 1, 0, '0, 0, 1, 0, 32'h900);
      check_eq("rst_stall_pc_const", 64'(pc), 64'd30);

      // Randomised mixed traffic.
      for (int i = 0; i < 300; i++) begin
         cyc($sformatf("rnd%0d", i),
             ($urandom_range(39) == 0), ($urandom_range(4) == 0),
             ($urandom_range(7) == 0), AW'($urandom),
             ($urandom_range(3) == 0), ($urandom_range(3) == 0),
             ($urandom_range(3) == 0), AW'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
